// File: rtl/acc_wbuf_pkg.sv
// Shared types and defaults for the accelerator write-buffer drain block.
package acc_wbuf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_REQ,
        ST_STREAM,
        ST_RESP
    } state_e;

    localparam int unsigned DEF_BURST_LEN  = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 64;
    localparam int unsigned WMST_LEN_W     = 9;

endpackage

// File: rtl/acc_wbuf_fifo.sv
// First-word-fall-through result buffer with occupancy count; caller guarantees
// no push when full and no pop when empty.
module acc_wbuf_fifo #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         pop_data,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because the depth is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/acc_wbuf_drain.sv
// Buffers conv-engine result words and drains them as incrementing-address bursts
// to the AXI write master. Define ACC_WBUF_STATS_EN to add beat/burst counters.
module acc_wbuf_drain
    import acc_wbuf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned WORD_BYTE  = DATA_WIDTH / 8,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   op_start,
    input  logic [ADDR_WIDTH-1:0]  base_addr,
    input  logic                   end_conv,
    input  logic                   res_valid,
    input  logic [DATA_WIDTH-1:0]  res_data,
    output logic                   res_ready,
    output logic                   wmst_req,
    output logic [ADDR_WIDTH-1:0]  wmst_addr,
    output logic [WMST_LEN_W-1:0]  wmst_len,
    input  logic                   wmst_ack,
    output logic                   wmst_tvalid,
    output logic [DATA_WIDTH-1:0]  wmst_tdata,
    input  logic                   wmst_tready,
    input  logic                   wmst_done,
    output logic                   write_buffer_wait
`ifdef ACC_WBUF_STATS_EN
    ,
    output logic [31:0]            stat_beats,
    output logic [15:0]            stat_bursts
`endif
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [WMST_LEN_W-1:0]   len_q, len_d;
    logic [WMST_LEN_W-1:0]   beats_q, beats_d;
    logic                    flush_q, flush_d;
    logic [CNT_W-1:0]        count;
    logic [DATA_WIDTH-1:0]   fifo_data;
    logic                    push, pop;

    acc_wbuf_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (res_data),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (count)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        beats_d     = beats_q;
        flush_d     = flush_q;
        res_ready   = (count != CNT_W'(FIFO_DEPTH));
        push        = res_valid && res_ready;
        wmst_req    = 1'b0;
        wmst_tvalid = (state_q == ST_STREAM) && (beats_q != '0);
        pop         = wmst_tvalid && wmst_tready;

        case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    addr_d  = base_addr;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (count >= CNT_W'(BURST_LEN)) begin
                    len_d   = WMST_LEN_W'(BURST_LEN);
                    state_d = ST_REQ;
                end else if (flush_q && count != '0) begin
                    len_d   = WMST_LEN_W'(count);
                    state_d = ST_REQ;
                end else if (flush_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                wmst_req = 1'b1;
                if (wmst_ack) begin
                    beats_d = len_q;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (pop) begin
                    beats_d = beats_q - 1'b1;
                    if (beats_q == WMST_LEN_W'(1)) state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (wmst_done) begin
                    addr_d  = addr_q + ADDR_WIDTH'(len_q) * ADDR_WIDTH'(WORD_BYTE);
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flag clears on return to IDLE only, so an end_conv seen while idle
        // still flushes the run started by the next op_start.
        if (state_q != ST_IDLE && state_d == ST_IDLE) flush_d = 1'b0;
        if (end_conv) flush_d = 1'b1;

        wmst_addr  = addr_q;
        wmst_len   = len_q;
        wmst_tdata = wmst_tvalid ? fifo_data : '0;
        write_buffer_wait = (state_q != ST_IDLE && state_q != ST_FILL) ||
                            (count != '0) ||
                            (state_q == ST_FILL && flush_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            beats_q <= '0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beats_q <= beats_d;
            flush_q <= flush_d;
        end
    end

`ifdef ACC_WBUF_STATS_EN
    logic [31:0] stat_beats_q, stat_beats_d;
    logic [15:0] stat_bursts_q, stat_bursts_d;

    always_comb begin
        stat_beats_d  = stat_beats_q;
        stat_bursts_d = stat_bursts_q;
        if (state_q == ST_IDLE && op_start) begin
            stat_beats_d  = '0;
            stat_bursts_d = '0;
        end else begin
            if (pop && stat_beats_q != '1) stat_beats_d = stat_beats_q + 1'b1;
            if (state_q == ST_RESP && wmst_done && stat_bursts_q != '1)
                stat_bursts_d = stat_bursts_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_beats_q  <= '0;
            stat_bursts_q <= '0;
        end else begin
            stat_beats_q  <= stat_beats_d;
            stat_bursts_q <= stat_bursts_d;
        end
    end

    assign stat_beats  = stat_beats_q;
    assign stat_bursts = stat_bursts_q;
`endif

endmodule

// File: tb/tb_acc_wbuf_drain.sv
// Self-checking bench for acc_wbuf_drain: table vectors, directed corner cases
// and randomized runs checked against a burst-carving reference model.
`timescale 1ns/1ps
module tb_acc_wbuf_drain;

    localparam int unsigned DW = 512;
    localparam int unsigned AW = 64;
    localparam int unsigned BL = 16;
    localparam int unsigned WB = DW / 8;

    logic          clk = 1'b0;
    logic          rst, op_start, end_conv, res_valid, res_ready;
    logic          wmst_req, wmst_ack, wmst_tvalid, wmst_tready, wmst_done;
    logic          write_buffer_wait;
    logic [AW-1:0] base_addr, wmst_addr;
    logic [DW-1:0] res_data, wmst_tdata;
    logic [8:0]    wmst_len;
`ifdef ACC_WBUF_STATS_EN
    logic [31:0]   stat_beats;
    logic [15:0]   stat_bursts;
`endif

    always #5 clk = ~clk;

    acc_wbuf_drain #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (64),
        .BURST_LEN  (BL)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .op_start          (op_start),
        .base_addr         (base_addr),
        .end_conv          (end_conv),
        .res_valid         (res_valid),
        .res_data          (res_data),
        .res_ready         (res_ready),
        .wmst_req          (wmst_req),
        .wmst_addr         (wmst_addr),
        .wmst_len          (wmst_len),
        .wmst_ack          (wmst_ack),
        .wmst_tvalid       (wmst_tvalid),
        .wmst_tdata        (wmst_tdata),
        .wmst_tready       (wmst_tready),
        .wmst_done         (wmst_done),
        .write_buffer_wait (write_buffer_wait)
`ifdef ACC_WBUF_STATS_EN
        ,
        .stat_beats        (stat_beats),
        .stat_bursts       (stat_bursts)
`endif
    );

    typedef struct {
        logic [AW-1:0] addr;
        int            len;
    } burst_t;

    typedef struct {
        logic [AW-1:0] base;
        int            n;
        bit            stall;
        bit            gaps;
        int            exp_nb;
        int            exp_last_len;
        logic [AW-1:0] exp_last_addr;
    } vec_t;

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    burst_t        obs_q[$];
    burst_t        mdl_q[$];
    logic [DW-1:0] exp_q[$];
    bit            ack_en = 1'b1;
    bit            stall_en = 1'b0;
    int            beats_left = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    logic          slave_done = 1'b0;
    logic          spur_done = 1'b0;

    assign wmst_done = slave_done | spur_done;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk64(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int unsigned i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // Reference: all words buffered before the flush, carved greedily into
    // BL-beat bursts with a short tail, addresses advancing by bytes written.
    task automatic build_model(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        int rem, l;
        mdl_q.delete();
        a = base;
        rem = n;
        while (rem > 0) begin
            l = (rem < int'(BL)) ? rem : int'(BL);
            mdl_q.push_back('{addr: a, len: l});
            a = a + AW'(l * int'(WB));
            rem -= l;
        end
    endtask

    initial begin : cycle_counter
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Write-master model: acks requests, stalls tready, returns done after a burst.
    initial begin : slave_drive
        wmst_ack = 1'b0;
        wmst_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            slave_done = 1'b0;
            if (!rst && done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    slave_done = 1'b1;
                    done_cyc = cyc;
                end
            end
            wmst_ack = wmst_req && ack_en && !rst;
            wmst_tready = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin : beat_monitor
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                beats_left = 0;
                done_cnt = 0;
            end else begin
                if (wmst_req && wmst_ack) begin
                    obs_q.push_back('{addr: wmst_addr, len: int'(wmst_len)});
                    beats_left = int'(wmst_len);
                end
                if (wmst_tvalid && wmst_tready) begin
                    checks++;
                    if (exp_q.size() == 0 || beats_left == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected: got beat low64 0x%0h with nothing outstanding",
                                 wmst_tdata[63:0]);
                    end else begin
                        e = exp_q.pop_front();
                        if (wmst_tdata !== e) begin
                            errors++;
                            $display("FAIL beat_data: got low64 0x%0h expected low64 0x%0h",
                                     wmst_tdata[63:0], e[63:0]);
                        end
                        beats_left--;
                        if (beats_left == 0) done_cnt = 4;
                    end
                end
            end
        end
    end

    task automatic start(input logic [AW-1:0] b);
        obs_q.delete();
        op_start = 1'b1;
        base_addr = b;
        tick();
        op_start = 1'b0;
    endtask

    task automatic pulse_end();
        end_conv = 1'b1;
        tick();
        end_conv = 1'b0;
    endtask

    task automatic push_words(input int n, input bit gaps);
        logic [DW-1:0] d;
        bit rdy;
        int waited;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                res_valid = 1'b0;
                tick();
            end
            d = rnd_word();
            res_valid = 1'b1;
            res_data = d;
            waited = 0;
            forever begin
                rdy = res_ready;
                tick();
                if (rdy) break;
                waited++;
                if (waited > 3000) break;
            end
            if (!rdy) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: res_ready stuck 0 at word %0d of %0d", i, n);
                res_valid = 1'b0;
                return;
            end
            exp_q.push_back(d);
        end
        res_valid = 1'b0;
    endtask

    task automatic wait_idle(output int fall);
        fall = -1;
        for (int i = 0; i < 4000; i++) begin
            if (!write_buffer_wait) begin
                fall = cyc;
                break;
            end
            tick();
        end
        if (fall < 0) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: write_buffer_wait got 1 after 4000 cycles, expected 0");
        end
    endtask

    task automatic wait_tvalid();
        for (int i = 0; i < 200; i++) begin
            if (wmst_tvalid) return;
            tick();
        end
        checks++;
        errors++;
        $display("FAIL wait_tvalid: wmst_tvalid got 0 for 200 cycles, expected 1");
    endtask

    task automatic check_run(input logic [AW-1:0] base, input int n);
        build_model(base, n);
        chk("burst_count", obs_q.size(), mdl_q.size());
        for (int i = 0; i < mdl_q.size() && i < obs_q.size(); i++) begin
            chk64("burst_addr", obs_q[i].addr, mdl_q[i].addr);
            chk("burst_len", obs_q[i].len, mdl_q[i].len);
        end
        chk("words_unwritten", exp_q.size(), 0);
`ifdef ACC_WBUF_STATS_EN
        chk("stat_beats", int'(stat_beats), n);
        chk("stat_bursts", int'(stat_bursts), mdl_q.size());
`endif
    endtask

    task automatic run_txn(input logic [AW-1:0] base, input int n, input bit stall, input bit gaps);
        int fall;
        stall_en = stall;
        start(base);
        push_words(n, gaps);
        pulse_end();
        wait_idle(fall);
        check_run(base, n);
        chk("wait_fall_after_done", fall - done_cyc, 2);
        stall_en = 1'b0;
        repeat (3) tick();
    endtask

    initial begin : main
        vec_t vecs[5];
        int   hi;
        int   fall;
        bit   seen;

        vecs[0] = '{64'h1000, 32, 1'b0, 1'b0, 2, 16, 64'h1400};
        vecs[1] = '{64'h2000, 20, 1'b0, 1'b0, 2, 4, 64'h2400};
        vecs[2] = '{64'h40, 1, 1'b0, 1'b0, 1, 1, 64'h40};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FC00, 40, 1'b1, 1'b1, 3, 8, 64'h400};
        vecs[4] = '{64'h3000, 16, 1'b1, 1'b1, 1, 16, 64'h3000};

        #20_000_000 ;
    end

    initial begin : sequencer
        vec_t vecs[5];
        int   hi;
        int   fall;
        bit   seen;
        logic [AW-1:0] rb;
        int   rn;

        vecs[0] = '{64'h1000, 32, 1'b0, 1'b0, 2, 16, 64'h1400};
        vecs[1] = '{64'h2000, 20, 1'b0, 1'b0, 2, 4, 64'h2400};
        vecs[2] = '{64'h40, 1, 1'b0, 1'b0, 1, 1, 64'h40};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_FC00, 40, 1'b1, 1'b1, 3, 8, 64'h400};
        vecs[4] = '{64'h3000, 16, 1'b1, 1'b1, 1, 16, 64'h3000};

        rst = 1'b1;
        op_start = 1'b0;
        end_conv = 1'b0;
        res_valid = 1'b0;
        res_data = '0;
        base_addr = '0;
        repeat (3) tick();

        chk("rst_res_ready", int'(res_ready), 1);
        chk("rst_wmst_req", int'(wmst_req), 0);
        chk("rst_wmst_tvalid", int'(wmst_tvalid), 0);
        chk("rst_wbuf_wait", int'(write_buffer_wait), 0);
        chk64("rst_wmst_addr", wmst_addr, 64'h0);
        chk("rst_wmst_len", int'(wmst_len), 0);
        chk("rst_tdata_zero", int'(wmst_tdata == '0), 1);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].base, vecs[v].n, vecs[v].stall, vecs[v].gaps);
            chk("tbl_nbursts", obs_q.size(), vecs[v].exp_nb);
            if (obs_q.size() > 0) begin
                chk("tbl_last_len", obs_q[$].len, vecs[v].exp_last_len);
                chk64("tbl_last_addr", obs_q[$].addr, vecs[v].exp_last_addr);
            end
        end

        // Empty flush: one cycle of wait, no request.
        start(64'hB000);
        pulse_end();
        hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (write_buffer_wait) hi++;
            if (wmst_req) seen = 1'b1;
            tick();
        end
        chk("empty_wait_cycles", hi, 1);
        chk("empty_no_req", int'(seen), 0);
        chk("empty_no_burst", obs_q.size(), 0);

        // Spurious done while in FILL must not advance the address.
        start(64'h5000);
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        push_words(20, 1'b0);
        pulse_end();
        wait_idle(fall);
        check_run(64'h5000, 20);

        // op_start during STREAM is ignored.
        start(64'h6000);
        push_words(16, 1'b0);
        wait_tvalid();
        op_start = 1'b1;
        base_addr = 64'h9999_0000;
        tick();
        op_start = 1'b0;
        push_words(16, 1'b0);
        pulse_end();
        wait_idle(fall);
        check_run(64'h6000, 32);

        // Backpressure: ack held low fills the buffer.
        ack_en = 1'b0;
        start(64'hA000);
        push_words(64, 1'b0);
        chk("bp_ready_low_at_64", int'(res_ready), 0);
        res_valid = 1'b1;
        res_data = rnd_word();
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (res_ready) seen = 1'b1;
            tick();
        end
        res_valid = 1'b0;
        chk("bp_ready_stays_low", int'(seen), 0);
        ack_en = 1'b1;
        push_words(6, 1'b0);
        pulse_end();
        wait_idle(fall);
        check_run(64'hA000, 70);
        chk64("bp_fifth_addr", (obs_q.size() == 5) ? obs_q[4].addr : 64'hDEAD, 64'hB000);

        // Randomized runs against the model.
        for (int r = 0; r < 6; r++) begin
            rb = {$urandom, $urandom};
            rn = $urandom_range(1, 90);
            run_txn(rb, rn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset after 5 beats of a burst.
        start(64'h7000);
        push_words(16, 1'b0);
        wait_tvalid();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_tvalid", int'(wmst_tvalid), 0);
        chk("rst_mid_req", int'(wmst_req), 0);
        chk("rst_mid_wbuf_wait", int'(write_buffer_wait), 0);
        chk("rst_mid_res_ready", int'(res_ready), 1);
`ifdef ACC_WBUF_STATS_EN
        chk("rst_mid_stat_beats", int'(stat_beats), 0);
`endif
        rst = 1'b0;
        exp_q.delete();
        tick();
        start(64'h8000);
        pulse_end();
        repeat (40) tick();
        chk("rst_mid_fifo_emptied", obs_q.size(), 0);
        chk("rst_mid_wait_low", int'(write_buffer_wait), 0);
        run_txn(64'h8000, 18, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
